// File: rtl/output_io_arbiter_if.sv
// Requester/pad bundle for output_io_arbiter: requests and data words in, grant/status and serial pad data out.
interface output_io_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*DATA_W-1:0] DATA;
  logic [NUM_REQ-1:0]        GNT;
  logic                      DONE;
  logic                      BUSY;
  logic                      OQI;

  modport master (
    output REQ, DATA,
    input  GNT, DONE, BUSY, OQI
  );

  modport slave (
    input  REQ, DATA,
    output GNT, DONE, BUSY, OQI
  );
endinterface

// File: rtl/output_io_arbiter.sv
// Round-robin arbiter serialising one requester's word LSB-first onto a shared output pad, with an idle gap between frames.
// Optional even-parity trailer bit when OUTPUT_IO_ARB_PARITY_EN is defined.
module output_io_arbiter #(
  parameter int   NUM_REQ    = 4,
  parameter int   DATA_W     = 8,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 IQC,
  input  logic                 QRT,
  output_io_arbiter_if.slave   bus
);

`ifdef OUTPUT_IO_ARB_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = DATA_W + PAR_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int PTR_W      = $clog2(NUM_REQ);
  localparam int GAP_W      = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [NUM_REQ-1:0] gnt, gnt_nxt;
  logic               done, done_nxt;
  logic               busy, busy_nxt;
  logic               oqi, oqi_nxt;

  logic [DATA_W-1:0]  sh;
  logic [DATA_W-1:0]  sh_shr;
  logic               load;
  logic               shift_en;
  logic               arb;

  logic [DATA_W-1:0]  words [NUM_REQ];
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_word;

`ifdef OUTPUT_IO_ARB_PARITY_EN
  logic               par_bit;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.DATA[i*DATA_W +: DATA_W];
  end

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!win_found && bus.REQ[PTR_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign win_word = words[win_idx];
  assign sh_shr   = sh >> 1;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    gnt_nxt     = '0;
    done_nxt    = 1'b0;
    oqi_nxt     = IDLE_LEVEL;
    load        = 1'b0;
    shift_en    = 1'b0;
    arb         = 1'b0;

    case (state)
      S_IDLE: arb = 1'b1;
      S_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          done_nxt = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = GAP_W'(GAP_CYCLES - 1);
          end else begin
            arb = 1'b1;
          end
        end else begin
          shift_en    = 1'b1;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          oqi_nxt     = sh_shr[0];
`ifdef OUTPUT_IO_ARB_PARITY_EN
          if (bit_cnt == CNT_W'(DATA_W - 1))
            oqi_nxt = par_bit;
`endif
        end
      end
      S_GAP: begin
        if (gap_cnt == '0)
          arb = 1'b1;
        else
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    // Arbitration edge: a win starts the next frame immediately, even on the DONE edge.
    if (arb) begin
      if (win_found) begin
        gnt_nxt     = NUM_REQ'(1) << win_idx;
        load        = 1'b1;
        oqi_nxt     = win_word[0];
        bit_cnt_nxt = '0;
        state_nxt   = S_SHIFT;
        ptr_nxt     = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
      end else begin
        state_nxt = S_IDLE;
      end
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      state   <= S_IDLE;
      ptr     <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      oqi     <= IDLE_LEVEL;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
      oqi     <= oqi_nxt;
    end
  end

  // Word storage is datapath only; the control state decides when it is meaningful.
  always_ff @(posedge IQC) begin
    if (load)
      sh <= win_word;
    else if (shift_en)
      sh <= sh_shr;
  end

`ifdef OUTPUT_IO_ARB_PARITY_EN
  always_ff @(posedge IQC) begin
    if (load)
      par_bit <= ^win_word;
  end
`endif

  assign bus.GNT  = gnt;
  assign bus.DONE = done;
  assign bus.BUSY = busy;
  assign bus.OQI  = oqi;

endmodule

// File: tb/tb_output_io_arbiter.sv
// Bench for output_io_arbiter: vector table, multi-cycle corner sequences and a randomized timeline-model comparison.
module tb_output_io_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
`ifdef OUTPUT_IO_ARB_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L  = DW + PAR;
  localparam int NC = 700;
  localparam int NA = NC + 64;

  logic clk = 1'b0;
  logic qrt0, qrt1;
  always #5 clk = ~clk;

  output_io_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus0 ();
  output_io_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus1 ();

  output_io_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(1), .IDLE_LEVEL(1'b1))
    dut0 (.IQC(clk), .QRT(qrt0), .bus(bus0));
  output_io_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1))
    dut1 (.IQC(clk), .QRT(qrt1), .bus(bus1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  word;
  } vec_t;

  vec_t tbl [6];

  // Timeline model: expected outputs after edge t, for each of the two instances.
  logic [3:0] e_gnt  [2][NA];
  bit         e_done [2][NA];
  bit         e_busy [2][NA];
  bit         e_oqi  [2][NA];
  int         nfree  [2];
  int         mptr   [2];
  int         gapc   [2];

  task automatic model(input int d, input int t, input logic [3:0] req, input logic [31:0] data);
    int w;
    logic [7:0] word;
    if (t < nfree[d]) return;
    if (req == 4'b0) begin
      nfree[d] = t + 1;
      return;
    end
    w = -1;
    for (int o = 0; o < NR; o++) begin
      int i;
      i = (mptr[d] + o) % NR;
      if (w < 0 && req[i]) w = i;
    end
    word = 8'(data >> (w * DW));
    e_gnt[d][t] = 4'(1 << w);
    for (int n = 0; n < DW; n++) e_oqi[d][t+n] = word[n];
`ifdef OUTPUT_IO_ARB_PARITY_EN
    e_oqi[d][t+DW] = ^word;
`endif
    e_done[d][t+L] = 1'b1;
    for (int k = t; k < t + L + gapc[d]; k++) e_busy[d][k] = 1'b1;
    nfree[d] = t + L + gapc[d];
    mptr[d]  = (w + 1) % NR;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [7:0] got;
    got = '0;
    bus0.REQ  = v.req;
    bus0.DATA = v.data;
    @(negedge clk);
    chk($sformatf("v%0d_gnt", k), bus0.GNT, v.gnt);
    chk($sformatf("v%0d_busy", k), bus0.BUSY, 1);
    got[0] = bus0.OQI;
    bus0.REQ  = '0;
    bus0.DATA = ~v.data;
    for (int n = 1; n < DW; n++) begin
      @(negedge clk);
      got[n] = bus0.OQI;
      chk($sformatf("v%0d_quiet%0d", k, n), {bus0.GNT, bus0.DONE}, 5'b0);
    end
    chk($sformatf("v%0d_word", k), got, v.word);
`ifdef OUTPUT_IO_ARB_PARITY_EN
    @(negedge clk);
    chk($sformatf("v%0d_parity", k), {bus0.DONE, bus0.OQI}, {1'b0, ^v.word});
`endif
    @(negedge clk);
    chk($sformatf("v%0d_done", k), {bus0.DONE, bus0.OQI, bus0.BUSY}, 3'b111);
    @(negedge clk);
    chk($sformatf("v%0d_idle", k), {bus0.DONE, bus0.OQI, bus0.BUSY}, 3'b010);
  endtask

  initial begin
    logic [7:0] got;

    tbl[0] = '{req: 4'b0100, data: 32'h11A5_3344, gnt: 4'b0100, word: 8'hA5};
    tbl[1] = '{req: 4'b0011, data: 32'h1234_5678, gnt: 4'b0001, word: 8'h78};
    tbl[2] = '{req: 4'b0011, data: 32'h9ABC_DEF0, gnt: 4'b0010, word: 8'hDE};
    tbl[3] = '{req: 4'b1001, data: 32'h3C00_00C3, gnt: 4'b1000, word: 8'h3C};
    tbl[4] = '{req: 4'b1110, data: 32'h00FF_0180, gnt: 4'b0010, word: 8'h01};
    tbl[5] = '{req: 4'b0001, data: 32'hFFFF_FFFF, gnt: 4'b0001, word: 8'hFF};

    bus0.REQ = '0; bus0.DATA = '0;
    bus1.REQ = '0; bus1.DATA = '0;
    qrt0 = 1'b0; qrt1 = 1'b0;

    // Reset held: activity on inputs must not disturb the outputs.
    for (int c = 0; c < 4; c++) begin
      bus0.REQ = 4'($urandom); bus0.DATA = $urandom;
      bus1.REQ = 4'($urandom); bus1.DATA = $urandom;
      @(negedge clk);
      chk("rst0", {bus0.GNT, bus0.DONE, bus0.BUSY, bus0.OQI}, 7'b0000_001);
      chk("rst1", {bus1.GNT, bus1.DONE, bus1.BUSY, bus1.OQI}, 7'b0000_001);
    end
    bus0.REQ = '0; bus1.REQ = '0;
    qrt0 = 1'b1; qrt1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst0", {bus0.GNT, bus0.DONE, bus0.BUSY, bus0.OQI}, 7'b0000_001);
    end

    for (int k = 0; k < 6; k++) run_vec(tbl[k], k);

    // Zero-gap instance: back-to-back frames, GNT and DONE on the same cycle.
    bus1.REQ  = 4'b0011;
    bus1.DATA = 32'h0000_5AC3;
    @(negedge clk);
    chk("g0_gnt_a", bus1.GNT, 4'b0001);
    got = '0;
    got[0] = bus1.OQI;
    for (int n = 1; n < DW; n++) begin @(negedge clk); got[n] = bus1.OQI; end
    chk("g0_word_a", got, 8'hC3);
`ifdef OUTPUT_IO_ARB_PARITY_EN
    @(negedge clk);
    chk("g0_par_a", bus1.OQI, ^8'hC3);
`endif
    @(negedge clk);
    chk("g0_gnt_done", {bus1.GNT, bus1.DONE, bus1.BUSY}, {4'b0010, 1'b1, 1'b1});
    got = '0;
    got[0] = bus1.OQI;
    bus1.REQ = '0;
    for (int n = 1; n < DW; n++) begin @(negedge clk); got[n] = bus1.OQI; end
    chk("g0_word_b", got, 8'h5A);
`ifdef OUTPUT_IO_ARB_PARITY_EN
    @(negedge clk);
    chk("g0_par_b", bus1.OQI, ^8'h5A);
`endif
    @(negedge clk);
    chk("g0_end", {bus1.GNT, bus1.DONE, bus1.BUSY, bus1.OQI}, 7'b0000_101);

    // Mid-frame reset: the frame is abandoned and the pointer restarts at 0.
    bus0.REQ  = 4'b1111;
    bus0.DATA = 32'h4433_2211;
    @(negedge clk);
    chk("mr_gnt", bus0.GNT, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    chk("mr_bit2", bus0.OQI, 1'b0);
    #2 qrt0 = 1'b0;
    #1 chk("mr_async", {bus0.GNT, bus0.DONE, bus0.BUSY, bus0.OQI}, 7'b0000_001);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mr_hold", {bus0.DONE, bus0.OQI}, 2'b01);
    end
    qrt0 = 1'b1;
    @(negedge clk);
    chk("mr_regnt", {bus0.GNT, bus0.OQI}, {4'b0001, 1'b1});
    bus0.REQ = '0;
    repeat (L + 1) @(negedge clk);
    chk("mr_idle", {bus0.BUSY, bus0.OQI}, 2'b01);

    // Randomized run against the timeline model.
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < NA; t++) begin
        e_gnt[d][t] = '0; e_done[d][t] = 1'b0; e_busy[d][t] = 1'b0; e_oqi[d][t] = 1'b1;
      end
      nfree[d] = 1;
      mptr[d]  = 0;
    end
    gapc[0] = 1;
    gapc[1] = 0;
    bus0.REQ = '0; bus1.REQ = '0;
    qrt0 = 1'b0; qrt1 = 1'b0;
    @(negedge clk);
    qrt0 = 1'b1; qrt1 = 1'b1;
    for (int e = 1; e < NC; e++) begin
      logic [3:0] r0, r1;
      r0 = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      bus0.REQ = r0; bus0.DATA = $urandom;
      bus1.REQ = r1; bus1.DATA = $urandom;
      model(0, e, r0, bus0.DATA);
      model(1, e, r1, bus1.DATA);
      @(negedge clk);
      chk($sformatf("rand0_t%0d", e), {bus0.GNT, bus0.DONE, bus0.BUSY, bus0.OQI},
          {e_gnt[0][e], e_done[0][e], e_busy[0][e], e_oqi[0][e]});
      chk($sformatf("rand1_t%0d", e), {bus1.GNT, bus1.DONE, bus1.BUSY, bus1.OQI},
          {e_gnt[1][e], e_done[1][e], e_busy[1][e], e_oqi[1][e]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/output_io_arbiter.md
Name: output_io_arbiter

Overview:
- Round-robin controller sharing one OUTPUT_IO pad among NUM_REQ fabric requesters.
- Grants one requester at a time and captures its DATA_W-bit word.
- Serialises the word LSB-first onto OQI, which drives the OUT_BUFF/VPR_OPAD path.
- Enforces a programmable idle gap between frames so the pad returns to a known level.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- DATA_W, 8: bits per frame; 1..32.
- GAP_CYCLES, 1: idle cycles between frames; 0..15.
- IDLE_LEVEL, 1'b1: OQI value when no frame is being sent.

Ports:
- IQC  input  1  clock; all state updates on the rising edge.
- QRT  input  1  reset; asynchronous, active-low.
- REQ  input  NUM_REQ  per-requester request level.
- DATA  input  NUM_REQ*DATA_W  requester i word at DATA[i*DATA_W +: DATA_W].
- GNT  output  NUM_REQ  one-hot, one-cycle pulse marking the captured requester.
- DONE  output  1  one-cycle pulse after the last data bit of a frame.
- BUSY  output  1  high in SHIFT and GAP states.
- OQI  output  1  serial pad data, fed to the output buffer.

Behaviour:
- Reset (QRT=0, asynchronous):
  - state=IDLE, OQI=IDLE_LEVEL, GNT=0, DONE=0, BUSY=0.
  - Round-robin pointer ptr=0, bit counter=0, gap counter=0.
  - Reset mid-frame aborts the frame immediately; no DONE is issued.
- States: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE:
  - If |REQ is high at edge k, the winner is the first i with REQ[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - At edge k: GNT[winner]=1 for one cycle, the shift register loads the winner's DATA slice, OQI=bit0, state=SHIFT, ptr=(winner+1) mod NUM_REQ.
  - If |REQ is low, stay in IDLE with OQI=IDLE_LEVEL.
- SHIFT:
  - Each edge shifts right one bit; OQI presents bit n in the n-th cycle after the grant.
  - Each bit is held for exactly one cycle.
  - DATA is sampled only at the grant edge; later DATA changes are ignored.
  - REQ deasserting after the grant does not abort the frame.
- End of frame: at the edge after bit DATA_W-1:
  - DONE=1 for one cycle and OQI=IDLE_LEVEL.
  - If GAP_CYCLES>0: state=GAP, gap counter=GAP_CYCLES-1.
  - If GAP_CYCLES=0: arbitration happens at that same edge. On a win, GNT and DONE pulse together and OQI=bit0 of the new word (back-to-back frames). Otherwise go to IDLE.
- GAP:
  - OQI=IDLE_LEVEL, counting down.
  - At the edge where the counter is 0, arbitrate exactly as in IDLE: grant goes directly to SHIFT, otherwise go to IDLE.
  - Requests that arrive during SHIFT or GAP are held by the requester and served only at that arbitration edge.
- Frame length: DATA_W cycles of data, plus GAP_CYCLES idle cycles.
- Fairness: a requester that holds REQ continuously waits at most NUM_REQ-1 frames.
- BUSY is high from the grant edge until the return to IDLE. It stays high across back-to-back frames.

Optional Feature:
- Macro: OUTPUT_IO_ARB_PARITY_EN.
- With it defined:
  - An even-parity bit (XOR of the captured word) is sent on OQI in one extra SHIFT cycle after bit DATA_W-1.
  - DONE pulses after the parity bit.
  - Frame length becomes DATA_W+1 data cycles.
- Without it:
  - No parity cycle and no parity logic.
  - Frame length is DATA_W cycles.

Test Plan:
- Reset: hold QRT=0 and toggle REQ/DATA -> OQI=1, GNT=0, DONE=0, BUSY=0. Release QRT -> nothing changes until REQ is asserted.
- Single frame, defaults: REQ=4'b0100, DATA slice2=8'hA5.
  - GNT=4'b0100 for one cycle.
  - OQI sequence over 8 cycles = 1,0,1,0,0,1,0,1.
  - Next cycle: DONE=1, OQI=1. One gap cycle follows, then IDLE with BUSY=0.
- Round-robin: REQ=4'b1111 held, slice i=8'h10+i -> grant order 0,1,2,3,0. Each frame is separated by 1 idle cycle.
- GAP_CYCLES=0, REQ=4'b0011 held -> DONE and GNT=4'b0010 pulse on the same cycle, and OQI has no idle cycle between frames.
- Mid-frame reset: pull QRT low after the 3rd data bit -> OQI=1 immediately and no DONE. After release, a still-held REQ restarts with ptr=0 ordering.
- Parity, with OUTPUT_IO_ARB_PARITY_EN: DATA=8'h07 -> 8 data bits, then parity bit 1, then DONE. Without the macro, DONE follows bit 7 directly.
